// File: rtl/sound_pkg.sv
// sound_pkg: shared constants, note sequence table and helpers for the Pong sound arbiter.
//   - Tone codes selecting one of the four square-wave generators.
//   - Event indices; a higher index means a higher priority.
//   - FSM state encodings (plain localparams so legacy tools can read them).
//   - note_t: one note of a sequence (tone code plus a length class).
//   - seq_note()/num_notes(): the fixed note sequence of every event.
//   - prio_pick(): index of the highest-priority set bit.
package sound_pkg;

  localparam logic [1:0] TONE_440  = 2'd0;
  localparam logic [1:0] TONE_500  = 2'd1;
  localparam logic [1:0] TONE_1000 = 2'd2;
  localparam logic [1:0] TONE_2000 = 2'd3;

  localparam logic [1:0] EVT_PADDLE    = 2'd0;
  localparam logic [1:0] EVT_WALL      = 2'd1;
  localparam logic [1:0] EVT_SCORE     = 2'd2;
  localparam logic [1:0] EVT_GAME_OVER = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Length classes; the cycle counts are resolved by sound_seq_rom parameters.
  localparam logic [1:0] LEN_SHORT = 2'd0;
  localparam logic [1:0] LEN_MED   = 2'd1;
  localparam logic [1:0] LEN_LONG  = 2'd2;

  localparam logic [2:0] NUM_NOTES_PADDLE    = 3'd1;
  localparam logic [2:0] NUM_NOTES_WALL      = 3'd1;
  localparam logic [2:0] NUM_NOTES_SCORE     = 3'd2;
  localparam logic [2:0] NUM_NOTES_GAME_OVER = 3'd4;

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] len_sel;
  } note_t;

  function automatic logic [2:0] num_notes(input logic [1:0] evt);
    logic [2:0] n;
    case (evt)
      EVT_PADDLE: n = NUM_NOTES_PADDLE;
      EVT_WALL:   n = NUM_NOTES_WALL;
      EVT_SCORE:  n = NUM_NOTES_SCORE;
      default:    n = NUM_NOTES_GAME_OVER;
    endcase
    return n;
  endfunction

  function automatic note_t seq_note(input logic [1:0] evt, input logic [1:0] idx);
    note_t n;
    n.code    = TONE_1000;
    n.len_sel = LEN_SHORT;
    case (evt)
      EVT_PADDLE: begin
        n.code    = TONE_1000;
        n.len_sel = LEN_SHORT;
      end
      EVT_WALL: begin
        n.code    = TONE_500;
        n.len_sel = LEN_SHORT;
      end
      EVT_SCORE: begin
        n.code    = (idx == 2'd0) ? TONE_500 : TONE_1000;
        n.len_sel = LEN_MED;
      end
      default: begin
        n.len_sel = LEN_LONG;
        case (idx)
          2'd0:    n.code = TONE_500;
          2'd1:    n.code = TONE_1000;
          2'd2:    n.code = TONE_2000;
          default: n.code = TONE_440;
        endcase
      end
    endcase
    return n;
  endfunction

  // Later assignments win, so the highest set index is returned.
  function automatic logic [1:0] prio_pick(input logic [3:0] p);
    logic [1:0] g;
    g = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) g = 2'(i);
    end
    return g;
  endfunction

endpackage

// File: rtl/sound_seq_rom.sv
// sound_seq_rom: combinational lookup of one note of an event's fixed sequence.
//   evt_i      - event index (EVT_*)
//   note_idx_i - note position inside the sequence
//   code_o     - tone code of that note
//   len_o      - note length in clock cycles
//   last_o     - high when this is the final note of the sequence
module sound_seq_rom
  import sound_pkg::*;
#(
  parameter int unsigned T_SHORT = 5_000_000,
  parameter int unsigned T_MED   = 10_000_000,
  parameter int unsigned T_LONG  = 50_000_000,
  parameter int unsigned CNT_W   = 26
) (
  input  logic [1:0]       evt_i,
  input  logic [1:0]       note_idx_i,
  output logic [1:0]       code_o,
  output logic [CNT_W-1:0] len_o,
  output logic             last_o
);

  note_t note;

  always_comb begin
    note   = seq_note(evt_i, note_idx_i);
    code_o = note.code;
    case (note.len_sel)
      LEN_SHORT: len_o = CNT_W'(T_SHORT);
      LEN_MED:   len_o = CNT_W'(T_MED);
      default:   len_o = CNT_W'(T_LONG);
    endcase
    last_o = ({1'b0, note_idx_i} == (num_notes(evt_i) - 3'd1));
  end

endmodule

// File: rtl/sound_arbiter.sv
// sound_arbiter: shares the single tone datapath among the four Pong sound events.
//   clk_100MHz - system clock
//   reset_n    - asynchronous active-low reset
//   req[3:0]   - one-cycle event pulses: 0=paddle 1=wall 2=score 3=game_over
//   tone_sel   - tone code for the speaker mux
//   tone_en    - speaker gate, high only while a note sounds
//   busy       - high while a sequence is playing (note or gap)
//   active_evt - event being played; holds its last value when idle
//   drop       - one-cycle pulse when a request is merged or discarded
// Build option: define SOUND_PREEMPT_EN to let a strictly higher-priority pending event
// abort the running sequence.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned T_SHORT  = 5_000_000,
  parameter int unsigned T_MED    = 10_000_000,
  parameter int unsigned T_LONG   = 50_000_000,
  parameter int unsigned T_GAP    = 10_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [1:0] tone_sel,
  output logic       tone_en,
  output logic       busy,
  output logic [1:0] active_evt,
  output logic       drop
);

  logic [3:0]       req_q, pending_q, pending_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       note_idx_q, note_idx_d;
  logic             last_q, last_d;
  logic [1:0]       tone_sel_q, tone_sel_d;
  logic             tone_en_q, tone_en_d;
  logic [1:0]       active_evt_q, active_evt_d;
  logic             drop_q, drop_d;

  logic [1:0]       grant_evt;
  logic             preempt, do_grant;
  logic [3:0]       granted;
  logic [1:0]       rom_evt, rom_idx, rom_code;
  logic [CNT_W-1:0] rom_len;
  logic             rom_last;

  always_comb begin
    grant_evt = prio_pick(pending_q);
`ifdef SOUND_PREEMPT_EN
    preempt = (state_q != ST_IDLE) && (|pending_q) && (grant_evt > active_evt_q);
`else
    preempt = 1'b0;
`endif
    do_grant = ((state_q == ST_IDLE) && (|pending_q)) || preempt;
    // One ROM serves both the first note of a grant and the next note after a gap.
    rom_evt  = do_grant ? grant_evt : active_evt_q;
    rom_idx  = do_grant ? 2'd0 : note_idx_q + 2'd1;
  end

  sound_seq_rom #(
    .T_SHORT(T_SHORT),
    .T_MED  (T_MED),
    .T_LONG (T_LONG),
    .CNT_W  (CNT_W)
  ) u_rom (
    .evt_i     (rom_evt),
    .note_idx_i(rom_idx),
    .code_o    (rom_code),
    .len_o     (rom_len),
    .last_o    (rom_last)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    note_idx_d   = note_idx_q;
    last_d       = last_q;
    tone_sel_d   = tone_sel_q;
    tone_en_d    = tone_en_q;
    active_evt_d = active_evt_q;
    drop_d       = preempt;
    granted      = 4'b0000;

    if (do_grant) begin
      granted      = 4'b0001 << grant_evt;
      active_evt_d = grant_evt;
      note_idx_d   = 2'd0;
      tone_sel_d   = rom_code;
      tone_en_d    = 1'b1;
      timer_d      = rom_len - CNT_W'(1);
      last_d       = rom_last;
      state_d      = ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (timer_q == '0) begin
            tone_en_d = 1'b0;
            timer_d   = CNT_W'(T_GAP - 1);
            state_d   = ST_GAP;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (timer_q == '0) begin
            if (!last_q) begin
              note_idx_d = note_idx_q + 2'd1;
              tone_sel_d = rom_code;
              tone_en_d  = 1'b1;
              timer_d    = rom_len - CNT_W'(1);
              last_d     = rom_last;
              state_d    = ST_PLAY;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    // A request landing on the bit being granted re-queues it instead of merging.
    pending_d = (pending_q & ~granted) | req_q;
    if (|(req_q & pending_q & ~granted)) drop_d = 1'b1;
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      req_q        <= 4'b0000;
      pending_q    <= 4'b0000;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      note_idx_q   <= 2'd0;
      last_q       <= 1'b0;
      tone_sel_q   <= 2'd0;
      tone_en_q    <= 1'b0;
      active_evt_q <= 2'd0;
      drop_q       <= 1'b0;
    end else begin
      req_q        <= req;
      pending_q    <= pending_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      note_idx_q   <= note_idx_d;
      last_q       <= last_d;
      tone_sel_q   <= tone_sel_d;
      tone_en_q    <= tone_en_d;
      active_evt_q <= active_evt_d;
      drop_q       <= drop_d;
    end
  end

  assign tone_sel   = tone_sel_q;
  assign tone_en    = tone_en_q;
  assign busy       = (state_q != ST_IDLE);
  assign active_evt = active_evt_q;
  assign drop       = drop_q;

endmodule
